// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: bundles the command, shifter and result signals
// of shift_sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whatever drives commands, provides the
// shifter result and consumes results.
interface shift_sequencer_if #(
    parameter int STEPS_W = 4
) ();
    // Command handshake
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [2:0]         in_amt;
    logic               in_dir;
    logic [STEPS_W-1:0] in_steps;

    // Downstream shifter operands and result
    logic [7:0]         sh_a;
    logic [2:0]         sh_amt;
    logic               sh_choice;
    logic [7:0]         sh_y;

    // Result handshake
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_steps,
        output in_ready,
        output sh_a, sh_amt, sh_choice,
        input  sh_y,
        output out_valid, out_data,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_amt, in_dir, in_steps,
        input  in_ready,
        input  sh_a, sh_amt, sh_choice,
        output sh_y,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts a (pattern, amount, direction, step count)
// command, applies the external 8-bit rotate unit to the pattern once
// every TICK_DIV cycles, feeding the result back, and presents the final
// pattern on a valid/ready result port.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the 'abort' input,
// which returns a running or finished sequence to IDLE.
module shift_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int STEPS_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_sequencer_if.slave    bus,
    output logic                busy
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_cur;
    logic [2:0]         r_amt;
    logic               r_dir;
    logic [STEPS_W-1:0] r_remaining;
    logic [PRE_W-1:0]   r_pre;

    logic               w_accept;
    logic               w_tick;
    logic               w_last_step;
    logic               w_release;
    logic               w_abort;

    // A command is only taken while idle; in_valid elsewhere is ignored.
    assign w_accept    = bus.in_valid && (r_state == S_IDLE);
    // A step edge: the prescaler has counted a full TICK_DIV period.
    assign w_tick      = (r_state == S_SHIFT) && (r_pre == PRE_LAST);
    assign w_last_step = w_tick && (r_remaining == STEPS_W'(1));
    // out_ready only matters while a result is being offered.
    assign w_release   = (r_state == S_DONE) && bus.out_ready;

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort has no effect in IDLE, so a coincident command is still taken.
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Next-state selection; abort overrides any step or handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.in_steps == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command capture and per-step feedback of the shifter result.
    // An aborted step edge leaves the pattern as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= 8'h00;
            r_amt       <= 3'd0;
            r_dir       <= 1'b0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_cur       <= bus.in_data;
            r_amt       <= bus.in_amt;
            r_dir       <= bus.in_dir;
            r_remaining <= bus.in_steps;
        end else if (w_tick && !w_abort) begin
            r_cur       <= bus.sh_y;
            r_remaining <= r_remaining - STEPS_W'(1);
        end
    end

    // Step-rate prescaler: counts 0..TICK_DIV-1 while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_accept || w_tick || (r_state != S_SHIFT)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // All outputs come straight from registers or the state decode.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_cur;
    assign bus.sh_a      = r_cur;
    assign bus.sh_amt    = r_amt;
    assign bus.sh_choice = r_dir;
    assign busy          = (r_state != S_IDLE);

endmodule
